dmrs_phase_sequencer: RTL and testbench
=======================================

// Module: dmrs_phase_sequencer
// PURPOSE
//   Phase-ramp controller for one shared sine/cosine LUT (15-bit phase in, WIDTH-bit sin/cos out).
//   Generates the phase sequence phase_init + n*phase_step (mod 2^15) for n = 0..seq_len-1.
//   Registers the returned sin/cos pair into a valid/ready output stage.
//   Used by DMRS cyclic-shift rotation e^{j*alpha*n}; sits between DMRS control and the mapper.
// PARAMETERS
//   WIDTH  9   sin/cos sample width; equals the LUT output width
//   LEN_W  12  sequence-length/index width (max 4095 samples; covers 273 PRB * 12)
// PORTS
//   clk         in   1      clock
//   rst         in   1      synchronous active-high reset
//   start       in   1      start request; accepted only while busy==0
//   phase_init  in   15     Q0.15 start phase (1.0 = 2*pi); latched on accepted start
//   phase_step  in   15     Q0.15 per-sample increment; latched on accepted start
//   seq_len     in   LEN_W  number of samples; latched on accepted start
//   busy        out  1      high from accepted start until done
//   done        out  1      one-cycle pulse after last sample handshake (or empty run)
//   lut_phase   out  15     phase driven to LUT (combinational from phase accumulator)
//   lut_sin     in   WIDTH  LUT sine for lut_phase, same cycle (combinational LUT)
//   lut_cos     in   WIDTH  LUT cosine for lut_phase, same cycle
//   out_valid   out  1      output sample valid
//   out_ready   in   1      downstream ready
//   out_sin     out  WIDTH  registered sine, passed through unmodified (LUT sign format)
//   out_cos     out  WIDTH  registered cosine, passed through unmodified
//   out_idx     out  LEN_W  sample index n of current output
//   out_last    out  1      high with out_valid on sample n = seq_len-1
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, out_valid, out_last = 0; out_sin, out_cos, out_idx, acc, cnt = 0; lut_phase = 0.
//   - FSM states:
//     - IDLE: start=1 and seq_len!=0 -> RUN; acc<=phase_init; cnt<=0; params latched.
//     - IDLE: start=1 and seq_len==0 -> FIN; no output produced.
//     - RUN: issue samples; on issuing sample seq_len-1 -> DRAIN.
//     - DRAIN: wait for handshake of the last sample (out_valid & out_ready & out_last) -> FIN.
//     - FIN: done=1 for exactly one cycle -> IDLE. busy=0 in IDLE only.
//   - Issue rule, RUN only: issue when (!out_valid || out_ready). On issue:
//     - out_sin<=lut_sin; out_cos<=lut_cos; out_idx<=cnt; out_last<=(cnt==seq_len-1); out_valid<=1.
//     - acc<=acc+phase_step; cnt<=cnt+1.
//   - lut_phase = acc at all times. acc wraps modulo 2^15 with the carry discarded; 0x7FFF+1 -> 0x0000.
//   - Backpressure: while out_valid & !out_ready, out_* hold; acc and cnt hold.
//   - Throughput: one sample per cycle when out_ready held high; no bubbles between samples.
//   - out_valid falls after a handshake with no new issue. DRAIN/FIN/IDLE never issue.
//   - Latency: start accepted at edge t -> out_valid=1 after edge t+1 (sample 0).
//     With out_ready=1, the last sample is valid after edge t+seq_len; done pulses after edge t+seq_len+1.
//   - Empty run (seq_len==0): start accepted at edge t -> done=1 after edge t+1; out_valid stays 0.
//   - Overlap rules:
//     - start while busy is ignored; latched params do not change.
//     - start sampled in the same cycle as done (FIN) is ignored.
//   - rst mid-run: next edge forces reset state. A sample pending handshake is dropped; no done pulse.
//   - phase_step=0 is legal and produces a constant phase.
// TESTING
//   1. init=0x0000, step=0x2000, len=4, out_ready=1 -> lut_phase 0x0000,0x2000,0x4000,0x6000 on consecutive cycles;
//      out_idx 0..3; out_last only at idx 3; done once, 1 cycle after the last handshake.
//   2. init=0x7000, step=0x2000, len=3 -> phases 0x7000,0x1000,0x3000 (wrap);
//      out_sin/out_cos equal the bench LUT model at those phases.
//   3. len=5; out_ready toggles 1,0,0,1,0,1,... -> every sample appears exactly once in order;
//      outputs stable while stalled; acc/cnt frozen during stall.
//   4. len=0 start -> done after edge t+1, busy high exactly 2 cycles, no out_valid.
//   5. start pulses during a len=8 run with different params -> ignored; 8 samples with the original step.
//   6. rst asserted after sample 2 handshake of a len=6 run -> all outputs at reset values next cycle; no done.
//      A following len=2 run completes normally.

Source files
------------

// File: rtl/dmrs_phase_sequencer.sv
// DMRS phase-ramp sequencer: drives a shared sin/cos LUT with
// phase_init + n*phase_step and registers the LUT result into a valid/ready stage.
module dmrs_phase_sequencer #(
  parameter int WIDTH = 9,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [14:0]      phase_init,
  input  logic [14:0]      phase_step,
  input  logic [LEN_W-1:0] seq_len,
  output logic             busy,
  output logic             done,
  output logic [14:0]      lut_phase,
  input  logic [WIDTH-1:0] lut_sin,
  input  logic [WIDTH-1:0] lut_cos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sin,
  output logic [WIDTH-1:0] out_cos,
  output logic [LEN_W-1:0] out_idx,
  output logic             out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t           state;
  logic [14:0]      acc;
  logic [14:0]      step_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] last_cnt;
  logic             issue;
  logic             hs;

  // Index of the final sample of the latched run.
  assign last_cnt  = len_q - LEN_W'(1);

  // A slot is free when nothing is held or the held sample leaves now.
  assign issue     = (state == RUN) && (!out_valid || out_ready);
  assign hs        = out_valid && out_ready;

  // The LUT is addressed straight from the accumulator.
  assign lut_phase = acc;

  // Control FSM, phase/index counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc       <= '0;
      step_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sin   <= '0;
      out_cos   <= '0;
      out_idx   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            step_q <= phase_step;
            len_q  <= seq_len;
            if (seq_len != '0) begin
              acc   <= phase_init;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= FIN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            out_sin   <= lut_sin;
            out_cos   <= lut_cos;
            out_idx   <= cnt;
            out_last  <= (cnt == last_cnt);
            out_valid <= 1'b1;
            acc       <= acc + step_q;
            cnt       <= cnt + LEN_W'(1);
            if (cnt == last_cnt) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end
        end
        FIN: begin
          // An empty run arrives here with done low and spends one
          // extra cycle so its pulse lands one edge after the start.
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmrs_phase_sequencer.sv
// Scoreboard bench for dmrs_phase_sequencer.
// Directed runs; a negedge monitor pops expected samples on each handshake.
module tb_dmrs_phase_sequencer;

  localparam int WIDTH = 9;
  localparam int LEN_W = 12;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [LEN_W-1:0] idx;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [14:0]      phase_init = '0;
  logic [14:0]      phase_step = '0;
  logic [LEN_W-1:0] seq_len = '0;
  logic             busy;
  logic             done;
  logic [14:0]      lut_phase;
  logic [WIDTH-1:0] lut_sin;
  logic [WIDTH-1:0] lut_cos;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sin;
  logic [WIDTH-1:0] out_cos;
  logic [LEN_W-1:0] out_idx;
  logic             out_last;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit empty_ok = 1'b0;
  bit done_pend = 1'b0;
  bit stall_prev = 1'b0;
  logic [WIDTH-1:0] p_sin, p_cos;
  logic [LEN_W-1:0] p_idx;
  logic             p_last;
  logic [14:0]      p_phase;
  exp_t exp_q[$];
  int pat_k = 0;
  logic [5:0] pat = 6'b101001;

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_sin(input logic [14:0] p);
    return p[14:6];
  endfunction

  function automatic logic [WIDTH-1:0] m_cos(input logic [14:0] p);
    return p[8:0] ^ 9'h155;
  endfunction

  assign lut_sin = m_sin(lut_phase);
  assign lut_cos = m_cos(lut_phase);

  dmrs_phase_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .phase_init(phase_init), .phase_step(phase_step), .seq_len(seq_len),
    .busy(busy), .done(done), .lut_phase(lut_phase),
    .lut_sin(lut_sin), .lut_cos(lut_cos),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sin(out_sin), .out_cos(out_cos),
    .out_idx(out_idx), .out_last(out_last)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: scoreboard pops, stall hold, done timing.
  always @(negedge clk) begin
    if (rst) begin
      done_pend  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (done_pend) begin
        chk("done_after_last", {31'd0, done}, 32'd1);
      end else if (done && !empty_ok) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end
      if (stall_prev) begin
        chk("stall_hold",
            {out_valid, out_last, out_idx, out_sin, out_cos},
            {1'b1, p_last, p_idx, p_sin, p_cos});
        chk("stall_acc", {17'd0, lut_phase}, {17'd0, p_phase});
      end
      done_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got idx %0d expected none", out_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sample", {out_last, out_idx, out_sin, out_cos},
              {e.last, e.idx, e.s, e.c});
        end
        if (out_last) done_pend = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      p_sin   = out_sin;
      p_cos   = out_cos;
      p_idx   = out_idx;
      p_last  = out_last;
      p_phase = lut_phase;
    end
  end

  task automatic push_run(input logic [14:0] init, input logic [14:0] step,
                          input int len);
    logic [14:0] ph;
    exp_t e;
    ph = init;
    for (int n = 0; n < len; n++) begin
      e.s    = m_sin(ph);
      e.c    = m_cos(ph);
      e.idx  = LEN_W'(n);
      e.last = (n == len - 1);
      exp_q.push_back(e);
      ph = ph + step;
    end
  endtask

  // Returns just after the accepting edge.
  task automatic do_start(input logic [14:0] init, input logic [14:0] step,
                          input int len);
    @(posedge clk);
    #1;
    push_run(init, step, len);
    start      = 1'b1;
    phase_init = init;
    phase_step = step;
    seq_len    = LEN_W'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (toggle) begin
        out_ready = pat[pat_k % 6];
        pat_k++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done");
    end
  endtask

  task automatic end_run(input int d0, input int dexp);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", done_cnt - d0, dexp);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    logic [14:0] ph1 [4];
    logic [14:0] ph2 [3];
    bit found;
    ph1 = '{15'h0000, 15'h2000, 15'h4000, 15'h6000};
    ph2 = '{15'h7000, 15'h1000, 15'h3000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {busy, done, out_valid, out_last}, 4'b0000);
    chk("rst_data", {out_sin, out_cos, out_idx}, '0);
    chk("rst_phase", {17'd0, lut_phase}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic ramp
    d0 = done_cnt;
    do_start(15'h0000, 15'h2000, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_phase", {17'd0, lut_phase}, {17'd0, ph1[i]});
    end
    wait_done(1'b0);
    end_run(d0, 1);

    // 2: wraparound
    d0 = done_cnt;
    do_start(15'h7000, 15'h2000, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_phase", {17'd0, lut_phase}, {17'd0, ph2[i]});
    end
    wait_done(1'b0);
    end_run(d0, 1);

    // 3: backpressure
    d0 = done_cnt;
    pat_k = 0;
    do_start(15'h0123, 15'h0456, 5);
    wait_done(1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    end_run(d0, 1);

    // 4: empty run
    d0 = done_cnt;
    empty_ok = 1'b1;
    do_start(15'h1111, 15'h0100, 0);
    @(negedge clk);
    chk("t4_c1", {busy, done, out_valid}, 3'b100);
    @(negedge clk);
    chk("t4_c2", {busy, done, out_valid}, 3'b110);
    @(negedge clk);
    chk("t4_c3", {busy, done, out_valid}, 3'b000);
    empty_ok = 1'b0;
    end_run(d0, 1);

    // 5: start while busy and during done
    d0 = done_cnt;
    do_start(15'h0100, 15'h0300, 8);
    start = 1'b1;
    phase_init = 15'h5555;
    phase_step = 15'h1234;
    seq_len = 12'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0);
    start = 1'b1;
    seq_len = 12'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_fin_start", {31'd0, busy}, 32'd0);
    end_run(d0, 1);

    // 6: reset mid-run
    d0 = done_cnt;
    do_start(15'h0000, 15'h0800, 6);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_idx == 12'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_found", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctrl", {busy, done, out_valid, out_last}, 4'b0000);
    chk("t6_rst_data", {out_sin, out_cos, out_idx}, '0);
    chk("t6_rst_phase", {17'd0, lut_phase}, 32'd0);
    chk("t6_dropped", exp_q.size(), 3);
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    out_ready = 1'b1;
    d0 = done_cnt;
    do_start(15'h2222, 15'h0111, 2);
    wait_done(1'b0);
    end_run(d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
